uart_tx_frame: RTL
==================

# uart_tx_frame

UART transmit framer for the serial link: accepts one parallel word on a valid strobe and serialises it onto the TX line as start bit, data bits (LSB first), optional parity bit and one stop bit. Each bit is held for a programmable number of clocks. The bit-timing counter mirrors the receiver's edge/bit counting, so both ends use the same prescale value. The block sits between the system-side data source and the TX pin.

## Interface
- DATA_WIDTH, 8, number of data bits per frame (5..9 supported)
- clk_utx  input  1  system clock; all state updates on rising edge
- rst_utx  input  1  asynchronous, active-high reset
- p_data_utx  input  DATA_WIDTH  parallel word to transmit
- data_valid_utx  input  1  single-cycle strobe; p_data_utx is valid when high
- par_en_utx  input  1  1 = insert parity bit after data
- par_typ_utx  input  1  0 = even parity, 1 = odd parity
- prescale_utx  input  6  clocks per bit, legal 1..32; 0 treated as 1
- tx_out_utx  output  1  serial line, idle high, registered
- busy_utx  output  1  high while a frame is in progress, registered

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset (async, while rst_utx high) forces state IDLE, tx_out_utx=1, busy_utx=0, edge and bit counters 0, holding registers 0.
- IDLE: tx_out_utx=1, busy_utx=0. data_valid_utx sampled high captures p_data_utx, par_en_utx, par_typ_utx and prescale_utx (P) into holding registers. State moves to START.
- data_valid_utx while busy_utx=1, or in the last STOP clock, is ignored. No queuing.
- Mid-frame changes on any input have no effect; only the captured copies are used.
- Parity bit = XOR of captured data for even parity, inverted for odd parity. It is computed from the captured word, not the live bus.
- Edge counter counts 0..P-1 within each bit. At P-1 it wraps to 0 and the bit ends.
- Bit counter indexes DATA bits 0..DATA_WIDTH-1. It clears on entry to DATA.
- Transitions at bit end:
  - START -> DATA
  - DATA (last index) -> PARITY if par_en, else STOP; other DATA bits advance the index
  - PARITY -> STOP
  - STOP -> IDLE
- Line values per state:
  - START: 0
  - DATA: data[index]
  - PARITY: parity bit
  - STOP: 1

## Timing
- Accept edge k (IDLE, data_valid_utx=1): immediately after edge k, tx_out_utx=0 and busy_utx=1.
- Each bit occupies exactly P clock cycles on tx_out_utx.
- Frame length F = P*(DATA_WIDTH+2) clocks without parity, P*(DATA_WIDTH+3) with parity.
- After edge k+F, state is IDLE, busy_utx=0, tx_out_utx=1.
- The earliest next accept is edge k+F+1, so there is a minimum one-clock idle gap. The line stays high throughout the gap.
- P=1: one bit per clock, and the edge counter stays at 0.
- Asserting reset mid-frame forces tx_out_utx=1 and busy_utx=0 asynchronously, without waiting for a clock. The frame is abandoned. After reset is released, the block waits in IDLE for a new strobe.
- tx_out_utx and busy_utx come straight from flops. There is no combinational path from any input.

## Test plan
- 8N1, P=1, p_data=0xA5 strobed at edge k:
  - Line shows 0,1,0,1,0,0,1,0,1,1 on cycles k..k+9.
  - busy high for 10 cycles, then busy=0 and line=1.
- P=4, par_en=1, par_typ=0, data=0x0F:
  - Each bit lasts 4 clocks.
  - Parity bit=0; total frame 44 clocks.
- Odd parity, data=0x07, P=2:
  - Parity bit=0, preceded by data bits 1,1,1,0,0,0,0,0.
  - Repeat with 0x03: parity bit=1.
- Strobe 0x55 at edge k, strobe 0xFF at k+3 (busy) and in the last STOP cycle:
  - Both later strobes are ignored; only 0x55 is sent.
  - A strobe at k+F+1 is accepted and sends a second frame.
- Change p_data/prescale/par_typ mid-frame (P=3 -> 8):
  - The frame completes using the captured values with unchanged bit timing.
- Assert rst_utx during DATA bit 3:
  - tx_out=1 and busy=0 before the next edge.
  - After release, a new strobe with 0x3C produces a clean, complete frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit is held for P clocks, where P is captured together with the word.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_utx,
  input  logic                  rst_utx,
  input  logic [DATA_WIDTH-1:0] p_data_utx,
  input  logic                  data_valid_utx,
  input  logic                  par_en_utx,
  input  logic                  par_typ_utx,
  input  logic [5:0]            prescale_utx,
  output logic                  tx_out_utx,
  output logic                  busy_utx
);

  // state  | meaning
  // IDLE   | line high, waiting for a strobe
  // START  | start bit (0)
  // DATA   | data bit r_bit_idx, LSB first
  // PARITY | parity bit of the captured word
  // STOP   | stop bit (1); strobes in this bit are ignored
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int IDX_W = (DATA_WIDTH > 8) ? 4 : 3;

  state_t                r_state;
  logic [4:0]            r_edge_cnt;
  logic [4:0]            r_p_m1;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_bit;

  logic [4:0] w_p_m1;
  logic       w_bit_end;
  logic       w_last_idx;

  // Prescale 0 behaves as 1; the counter compares against P-1.
  assign w_p_m1     = (prescale_utx == 6'd0) ? 5'd0 : 5'(prescale_utx - 6'd1);
  assign w_bit_end  = (r_edge_cnt == r_p_m1);
  assign w_last_idx = (r_bit_idx == IDX_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk_utx or posedge rst_utx) begin
    if (rst_utx) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= '0;
      r_p_m1     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      tx_out_utx <= 1'b1;
      busy_utx   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          tx_out_utx <= 1'b1;
          busy_utx   <= 1'b0;
          r_edge_cnt <= '0;
          if (data_valid_utx) begin
            r_shift    <= p_data_utx;
            r_par_en   <= par_en_utx;
            r_par_bit  <= (^p_data_utx) ^ par_typ_utx;
            r_p_m1     <= w_p_m1;
            r_state    <= S_START;
            tx_out_utx <= 1'b0;
            busy_utx   <= 1'b1;
          end
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          if (!w_bit_end) begin
            r_edge_cnt <= r_edge_cnt + 5'd1;
          end else begin
            r_edge_cnt <= '0;
            case (r_state)
              S_START: begin
                r_state    <= S_DATA;
                r_bit_idx  <= '0;
                tx_out_utx <= r_shift[0];
              end
              S_DATA: begin
                if (w_last_idx) begin
                  if (r_par_en) begin
                    r_state    <= S_PARITY;
                    tx_out_utx <= r_par_bit;
                  end else begin
                    r_state    <= S_STOP;
                    tx_out_utx <= 1'b1;
                  end
                end else begin
                  // Shift so the next data bit always sits at index 1.
                  r_bit_idx  <= r_bit_idx + 1'b1;
                  r_shift    <= r_shift >> 1;
                  tx_out_utx <= r_shift[1];
                end
              end
              S_PARITY: begin
                r_state    <= S_STOP;
                tx_out_utx <= 1'b1;
              end
              default: begin
                r_state    <= S_IDLE;
                tx_out_utx <= 1'b1;
                busy_utx   <= 1'b0;
              end
            endcase
          end
        end
        default: begin
          r_state    <= S_IDLE;
          tx_out_utx <= 1'b1;
          busy_utx   <= 1'b0;
        end
      endcase
    end
  end

endmodule
